// File: rtl/p4_writeback_if.sv
// Writeback stage bus: p3 commit request, decode read ports and debug/retire outputs.
// master drives the stage inputs (p3 + decode); slave is the writeback stage itself.
interface p4_writeback_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              writeRegp3;
    logic [AW-1:0]     regAddressp3;
    logic [DATA_W-1:0] aluOutput;
    logic              readEnable;
    logic [DATA_W-1:0] memData;
    logic              stall;
    logic [AW-1:0]     rdAddr1;
    logic [AW-1:0]     rdAddr2;
    logic [DATA_W-1:0] rdData1;
    logic [DATA_W-1:0] rdData2;
    logic              wbValid;
    logic [AW-1:0]     wbAddr;
    logic [DATA_W-1:0] wbData;
    logic [DATA_W-1:0] retireCount;

    modport master (
        output writeRegp3, regAddressp3, aluOutput, readEnable, memData, stall,
        output rdAddr1, rdAddr2,
        input  rdData1, rdData2, wbValid, wbAddr, wbData, retireCount
    );

    modport slave (
        input  writeRegp3, regAddressp3, aluOutput, readEnable, memData, stall,
        input  rdAddr1, rdAddr2,
        output rdData1, rdData2, wbValid, wbAddr, wbData, retireCount
    );
endinterface

// File: rtl/p4_writeback.sv
// Writeback: picks ALU or load data, commits it to the 8x16 register file, serves bypassed reads.
// Latency: one edge to commit; backpressure: stall suppresses the commit, there is no ready.
module p4_writeback #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    p4_writeback_if.slave bus
);
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] wdata;
    logic              we;

    assign wdata = bus.readEnable ? bus.memData : bus.aluOutput;
    assign we    = bus.writeRegp3 & ~bus.stall;

    // Same-cycle forwarding only for a write that will actually commit at the next edge.
    always_comb begin
        bus.rdData1 = regs[bus.rdAddr1];
        bus.rdData2 = regs[bus.rdAddr2];
        if (we && (bus.rdAddr1 == bus.regAddressp3))
            bus.rdData1 = wdata;
        if (we && (bus.rdAddr2 == bus.regAddressp3))
            bus.rdData2 = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            bus.wbValid     <= 1'b0;
            bus.wbAddr      <= '0;
            bus.wbData      <= '0;
            bus.retireCount <= '0;
        end else if (we) begin
            regs[bus.regAddressp3] <= wdata;
            bus.wbValid            <= 1'b1;
            bus.wbAddr             <= bus.regAddressp3;
            bus.wbData             <= wdata;
            bus.retireCount        <= bus.retireCount + DATA_W'(1);
        end else begin
            bus.wbValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_p4_writeback.sv
// Directed plus randomized bench for p4_writeback against an array-based register-file model.
module tb_p4_writeback;
    logic clk;
    logic rst_n;

    p4_writeback_if bus ();

    p4_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Architectural model
    logic [15:0] m_regs [8];
    logic [15:0] m_cnt;
    logic [15:0] m_data;
    logic [2:0]  m_addr;
    logic        m_vld;

    // Currently applied stimulus
    logic        t_w, t_re, t_st;
    logic [2:0]  t_a, t_r1, t_r2;
    logic [15:0] t_alu, t_md;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wval();
        return t_re ? t_md : t_alu;
    endfunction

    function automatic logic commit();
        return t_w && !t_st;
    endfunction

    function automatic logic [15:0] exp_rd(input logic [2:0] ra);
        if (commit() && ra == t_a) return wval();
        return m_regs[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_cnt  = 16'h0;
        m_data = 16'h0;
        m_addr = 3'h0;
        m_vld  = 1'b0;
    endtask

    task automatic drive(input logic w, input logic [2:0] a, input logic [15:0] alu,
                         input logic re, input logic [15:0] md, input logic st,
                         input logic [2:0] r1, input logic [2:0] r2);
        t_w = w; t_a = a; t_alu = alu; t_re = re; t_md = md; t_st = st; t_r1 = r1; t_r2 = r2;
        bus.writeRegp3   = w;
        bus.regAddressp3 = a;
        bus.aluOutput    = alu;
        bus.readEnable   = re;
        bus.memData      = md;
        bus.stall        = st;
        bus.rdAddr1      = r1;
        bus.rdAddr2      = r2;
    endtask

    task automatic check_reads(input string tag);
        chk({tag, ".rdData1"}, bus.rdData1, exp_rd(t_r1));
        chk({tag, ".rdData2"}, bus.rdData2, exp_rd(t_r2));
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".wbValid"}, 16'(bus.wbValid), 16'(m_vld));
        chk({tag, ".wbAddr"}, 16'(bus.wbAddr), 16'(m_addr));
        chk({tag, ".wbData"}, bus.wbData, m_data);
        chk({tag, ".retireCount"}, bus.retireCount, m_cnt);
    endtask

    // Entered just after negedge with stimulus applied; returns at the following negedge.
    task automatic step(input string tag);
        #1;
        check_reads({tag, ".pre"});
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (commit()) begin
            m_regs[t_a] = wval();
            m_vld  = 1'b1;
            m_addr = t_a;
            m_data = wval();
            m_cnt  = m_cnt + 16'd1;
        end else begin
            m_vld = 1'b0;
        end
        #1;
        check_state(tag);
        check_reads({tag, ".post"});
        @(negedge clk);
    endtask

    task automatic rand_step(input string tag, input logic force_commit);
        logic [2:0] a, r1, r2;
        logic w, st;
        a  = 3'($urandom_range(0, 7));
        r1 = ($urandom_range(0, 2) == 0) ? a : 3'($urandom_range(0, 7));
        r2 = ($urandom_range(0, 2) == 0) ? a : 3'($urandom_range(0, 7));
        w  = force_commit ? 1'b1 : 1'($urandom_range(0, 1));
        st = force_commit ? 1'b0 : ($urandom_range(0, 3) == 0);
        drive(w, a, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), st, r1, r2);
        step(tag);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_state("reset");
        check_reads("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ALU write then read back next cycle
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 16'hDEAD, 1'b0, 3'd0, 3'd1);
        step("alu_wr");
        chk("alu_wr.retire_one", bus.retireCount, 16'h0001);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd3, 3'd3);
        step("alu_rd");
        chk("alu_rd.const", bus.rdData1, 16'h1234);

        // Load select
        drive(1'b1, 3'd5, 16'h0055, 1'b1, 16'hBEEF, 1'b0, 3'd5, 3'd4);
        step("load");
        chk("load.wbData_const", bus.wbData, 16'hBEEF);

        // Bypass with a committing write
        drive(1'b1, 3'd2, 16'h0001, 1'b0, 16'h0, 1'b0, 3'd0, 3'd0);
        step("byp_seed");
        drive(1'b1, 3'd2, 16'h00AA, 1'b0, 16'h0, 1'b0, 3'd2, 3'd2);
        #1;
        chk("byp.pre_const", bus.rdData1, 16'h00AA);
        step("byp");

        // Stalled write is not forwarded and does not commit
        drive(1'b1, 3'd2, 16'h0001, 1'b0, 16'h0, 1'b0, 3'd0, 3'd0);
        step("byp_reseed");
        drive(1'b1, 3'd2, 16'h00AA, 1'b0, 16'h0, 1'b1, 3'd2, 3'd2);
        #1;
        chk("byp_stall.pre_const", bus.rdData2, 16'h0001);
        step("byp_stall");

        // Store / stray load commits nothing
        drive(1'b0, 3'd2, 16'h7777, 1'b1, 16'h9999, 1'b0, 3'd2, 3'd5);
        step("store");

        // Register 0 is writable
        drive(1'b1, 3'd0, 16'hA5A5, 1'b0, 16'h0, 1'b0, 3'd0, 3'd7);
        step("r0_wr");

        // Fill the counter to FFFF with random committing writes, then wrap
        while (m_cnt != 16'hFFFF) rand_step("fill", 1'b1);
        rand_step("wrap", 1'b1);
        chk("wrap.count_zero", bus.retireCount, 16'h0000);
        chk("wrap.valid", 16'(bus.wbValid), 16'h0001);

        for (int i = 0; i < 400; i++) rand_step("rand", 1'b0);

        // Make sure several registers are nonzero, then reset between edges
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 16'(16'h1000 + i), 1'b0, 16'h0, 1'b0, 3'd0, 3'd0);
            step("pre_arst");
        end
        drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0, 3'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0, 3'(2 * i), 3'(2 * i + 1));
            #1;
            check_reads("arst");
        end
        check_state("arst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd6, 16'h4321, 1'b0, 16'h0, 1'b0, 3'd6, 3'd1);
        step("post_arst");
        chk("post_arst.retire_one", bus.retireCount, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/p4_writeback.md
Name: p4_writeback

Overview:
- Writeback stage of the SIMPLE 5-stage pipeline, directly downstream of the execute/memory stage (p3).
- Selects the writeback value from either the ALU result or the load data returned by data memory.
- Commits that value to the 8 x 16-bit general register file it owns.
- Exposes two combinational read ports with same-cycle write bypass to the decode stage, plus a retired-write counter and last-write debug registers.

Parameters:
- DATA_W, 16, register and datapath width
- NREG, 8, number of general registers (address width 3)

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- writeRegp3  in  1  p3 register-write request for the instruction now in writeback
- regAddressp3  in  3  destination register
- aluOutput  in  16  ALU result from p3
- readEnable  in  1  instruction is a load; select memData
- memData  in  16  data-memory read data, valid in the same cycle as readEnable
- stall  in  1  suppresses commit this cycle
- rdAddr1  in  3  decode read port 1 address
- rdAddr2  in  3  decode read port 2 address
- rdData1  out  16  read port 1 data
- rdData2  out  16  read port 2 data
- wbValid  out  1  registered: a commit occurred at the last edge
- wbAddr  out  3  registered: last committed register
- wbData  out  16  registered: last committed value
- retireCount  out  16  count of committed register writes

Behaviour:
- Write data select (combinational): wdata = readEnable ? memData : aluOutput.
- Commit condition: we = writeRegp3 & ~stall.
- On posedge with we=1:
  - regs[regAddressp3] <= wdata.
  - wbValid <= 1, wbAddr <= regAddressp3, wbData <= wdata.
  - retireCount <= retireCount + 1, modulo 2^16; 16'hFFFF wraps to 0 with no flag.
- On posedge with we=0: wbValid <= 0. wbAddr, wbData, retireCount and all regs hold.
- Writeback latency is one edge: a value presented by p3 in cycle N is architecturally visible in regs from cycle N+1.
- Register 0 is an ordinary writable register; there is no hard-wired zero.
- Read ports are combinational: rdDataK = (we && rdAddrK == regAddressp3) ? wdata : regs[rdAddrK].
  - The bypass applies to each port independently; both ports may hit the same address.
  - The bypass is gated by we. A stalled write is not forwarded, and a non-write instruction is never forwarded.
- readEnable=1 with writeRegp3=0 (store or stray read) commits nothing; memData is ignored.
- Asynchronous reset (rst_n=0), effective immediately and independent of clk:
  - all regs = 0, wbValid = 0, wbAddr = 0, wbData = 0, retireCount = 0.
  - rdData1/rdData2 then read 0, unless a bypass condition is present on the inputs.
- Reset deasserted mid-stream: the first posedge with rst_n=1 behaves normally. There is no warm-up cycle.
- X on regAddressp3 or wdata while we=0 has no effect on state.

Test Plan:
- Reset then ALU writes: rst_n=0 for 2 cycles; release; writeRegp3=1, regAddressp3=3, aluOutput=16'h1234, readEnable=0 -> after edge: regs[3]=1234, wbValid=1, wbAddr=3, wbData=1234, retireCount=1; rdAddr1=3 reads 1234 next cycle.
- Load select: readEnable=1, memData=16'hBEEF, aluOutput=16'h0055, writeRegp3=1, regAddressp3=5 -> regs[5]=BEEF (not 0055), wbData=BEEF.
- Bypass: regs[2]=0001; in the same cycle writeRegp3=1, regAddressp3=2, aluOutput=16'h00AA, rdAddr1=rdAddr2=2 -> rdData1=rdData2=00AA before the edge and 00AA after it. Repeat with stall=1 -> both ports read 0001 and regs[2] stays 0001.
- Stall/no-write: stall=1 with writeRegp3=1, or writeRegp3=0 with readEnable=1 -> no register changes, wbValid=0, retireCount unchanged.
- Counter wrap: preload retireCount to FFFF via 65535 commits (or force); one more commit -> 0000, wbValid=1.
- Async reset mid-operation: assert rst_n=0 between clock edges while regs hold nonzero values -> all regs and outputs go to 0 before the next edge; the first write after release commits normally with retireCount=1.
